// File: rtl/constraint_sweep_ctrl_pkg.sv
// Shared types and constants for the constraint sweep controller.
package constraint_pkg;
  localparam int POS_W      = 32;
  localparam int FRAC_W     = 16;
  localparam int ANCHOR_IDX = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_FIN
  } sweep_state_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } point_t;
endpackage

// File: rtl/constraint_sweep_ctrl_if.sv
// Operand/result bundle between the sweep controller and the enforcement datapath.
interface constraint_sweep_ctrl_if;
  import constraint_pkg::*;

  // Operands are registered and held stable from the cycle after ISSUE until the next
  // ISSUE; the controller samples dp_x_res/dp_y_res exactly once, in its WRITE cycle.
  // There is no back-pressure: the datapath must settle within DP_LATENCY cycles.
  logic [POS_W-1:0] dp_up_x;
  logic [POS_W-1:0] dp_up_y;
  logic [POS_W-1:0] dp_x;
  logic [POS_W-1:0] dp_y;
  logic [POS_W-1:0] dp_down_x;
  logic [POS_W-1:0] dp_down_y;
  logic             dp_is_last;
  logic [POS_W-1:0] dp_x_res;
  logic [POS_W-1:0] dp_y_res;

  modport master (
    output dp_up_x, dp_up_y, dp_x, dp_y, dp_down_x, dp_down_y, dp_is_last,
    input  dp_x_res, dp_y_res
  );

  modport slave (
    input  dp_up_x, dp_up_y, dp_x, dp_y, dp_down_x, dp_down_y, dp_is_last,
    output dp_x_res, dp_y_res
  );
endinterface

// File: rtl/constraint_sweep_ctrl_point_buffer.sv
// Point-position register file: one write port, three neighbour read ports, one registered readout.
module point_buffer
  import constraint_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int AW       = $clog2(N_POINTS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  point_t        wdata,
  input  logic [AW-1:0] up_addr,
  input  logic [AW-1:0] cur_addr,
  input  logic [AW-1:0] down_addr,
  output point_t        up_data,
  output point_t        cur_data,
  output point_t        down_data,
  input  logic [AW-1:0] rd_addr,
  output point_t        rd_data
);

  point_t mem [N_POINTS];

  assign up_data   = mem[up_addr];
  assign cur_data  = mem[cur_addr];
  assign down_data = mem[down_addr];

  // Readout sees the pre-write value when it targets the entry being written this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_POINTS; k++) mem[k] <= '0;
      rd_data <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (32'(rd_addr) < 32'(N_POINTS)) rd_data <= mem[rd_addr];
      else                              rd_data <= '0;
    end
  end

endmodule

// File: rtl/constraint_sweep_ctrl.sv
// Gauss-Seidel sweep sequencer feeding an external constraint datapath.
// Optional macro DUAL_ANCHOR_EN: the last point is anchored as well as point 0.
module constraint_sweep_ctrl
  import constraint_pkg::*;
#(
  parameter int  N_POINTS   = 16,
  parameter int  ITERS      = 4,
  parameter int  DP_LATENCY = 1,
  localparam int AW         = $clog2(N_POINTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    load_we,
  input  logic [AW-1:0]           load_addr,
  input  logic [POS_W-1:0]        load_x,
  input  logic [POS_W-1:0]        load_y,
  input  logic [AW-1:0]           rd_addr,
  output logic [POS_W-1:0]        rd_x,
  output logic [POS_W-1:0]        rd_y,
  constraint_sweep_ctrl_if.master dp,
  output sweep_state_t            dbg_state
);

`ifdef DUAL_ANCHOR_EN
  localparam int LAST_I = N_POINTS - 2;
  if (N_POINTS < 3) begin : g_bad_dual
    $error("DUAL_ANCHOR_EN needs N_POINTS >= 3");
  end
`else
  localparam int LAST_I = N_POINTS - 1;
`endif

  if (N_POINTS < 2 || N_POINTS > 256) begin : g_bad_n
    $error("N_POINTS must be in 2..256");
  end
  if (ITERS < 1 || DP_LATENCY < 0 || FRAC_W >= POS_W) begin : g_bad_cfg
    $error("illegal ITERS/DP_LATENCY/format configuration");
  end

  localparam logic [AW-1:0] FIRST_I = AW'(ANCHOR_IDX + 1);

  sweep_state_t  state;
  logic [AW-1:0] i;
  logic [31:0]   iter;
  logic [31:0]   wait_cnt;

  logic          is_last_c;
  logic [AW-1:0] down_addr;
  logic          ld_en;
  logic          wb_en;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  point_t        buf_wdata;
  point_t        up_p, cur_p, down_p, rd_p;

  assign is_last_c = (32'(i) == 32'(N_POINTS - 1));
  assign down_addr = is_last_c ? i : i + AW'(1);

  // Write-back and host load share the single write port; they never overlap in time.
  assign wb_en     = (state == ST_WRITE);
  assign ld_en     = (state == ST_IDLE) && load_we && (32'(load_addr) < 32'(N_POINTS));
  assign buf_we    = wb_en | ld_en;
  assign buf_waddr = wb_en ? i : load_addr;
  assign buf_wdata = wb_en ? point_t'{x: dp.dp_x_res, y: dp.dp_y_res}
                           : point_t'{x: load_x, y: load_y};

  point_buffer #(.N_POINTS(N_POINTS), .AW(AW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (buf_we),
    .waddr     (buf_waddr),
    .wdata     (buf_wdata),
    .up_addr   (i - AW'(1)),
    .cur_addr  (i),
    .down_addr (down_addr),
    .up_data   (up_p),
    .cur_data  (cur_p),
    .down_data (down_p),
    .rd_addr   (rd_addr),
    .rd_data   (rd_p)
  );

  assign rd_x      = rd_p.x;
  assign rd_y      = rd_p.y;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      i             <= FIRST_I;
      iter          <= '0;
      wait_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      dp.dp_up_x    <= '0;
      dp.dp_up_y    <= '0;
      dp.dp_x       <= '0;
      dp.dp_y       <= '0;
      dp.dp_down_x  <= '0;
      dp.dp_down_y  <= '0;
      dp.dp_is_last <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            i     <= FIRST_I;
            iter  <= '0;
            busy  <= 1'b1;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          dp.dp_up_x   <= up_p.x;
          dp.dp_up_y   <= up_p.y;
          dp.dp_x      <= cur_p.x;
          dp.dp_y      <= cur_p.y;
          dp.dp_down_x <= down_p.x;
          dp.dp_down_y <= down_p.y;
`ifdef DUAL_ANCHOR_EN
          dp.dp_is_last <= 1'b0;
`else
          dp.dp_is_last <= is_last_c;
`endif
          wait_cnt <= '0;
          state    <= (DP_LATENCY > 0) ? ST_WAIT : ST_WRITE;
        end
        ST_WAIT: begin
          if (wait_cnt == 32'(DP_LATENCY - 1)) state <= ST_WRITE;
          else                                 wait_cnt <= wait_cnt + 32'd1;
        end
        ST_WRITE: begin
          if (32'(i) < 32'(LAST_I)) begin
            i     <= i + AW'(1);
            state <= ST_ISSUE;
          end else if (iter < 32'(ITERS - 1)) begin
            i     <= FIRST_I;
            iter  <= iter + 32'd1;
            state <= ST_ISSUE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_constraint_sweep_ctrl.sv
// Scoreboard bench for constraint_sweep_ctrl: instance a runs ITERS=1, instance b runs ITERS=3.
module tb_constraint_sweep_ctrl;
  import constraint_pkg::*;

`ifdef DUAL_ANCHOR_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  localparam int          N_UPD    = DUAL ? 2 : 3;
  localparam int          BUSY_A   = N_UPD * 3;
  localparam int          BUSY_B   = N_UPD * 3 * 3;
  localparam int          LAST_B   = DUAL ? 0 : 8;
  localparam logic [63:0] STEP1    = {32'h0001_0000, 32'hFFFF_0000};
  localparam logic [63:0] STEP3    = {32'h0003_0000, 32'hFFFD_0000};
  localparam logic [63:0] ANCH     = {32'h0005_0000, 32'h0003_0000};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start_a, load_we_a, busy_a, done_a;
  logic [1:0]  load_addr_a, rd_addr_a;
  logic [31:0] load_x_a, load_y_a, rd_x_a, rd_y_a;
  sweep_state_t dbg_a;
  logic        start_b, load_we_b, busy_b, done_b;
  logic [1:0]  load_addr_b, rd_addr_b;
  logic [31:0] load_x_b, load_y_b, rd_x_b, rd_y_b;
  sweep_state_t dbg_b;
  logic        dp_copy;

  constraint_sweep_ctrl_if dp_a ();
  constraint_sweep_ctrl_if dp_b ();

  // Bench datapath: either add (+1.0, -1.0) or copy the up-neighbour.
  assign dp_a.dp_x_res = dp_copy ? dp_a.dp_up_x : dp_a.dp_x + 32'h0001_0000;
  assign dp_a.dp_y_res = dp_copy ? dp_a.dp_up_y : dp_a.dp_y - 32'h0001_0000;
  assign dp_b.dp_x_res = dp_copy ? dp_b.dp_up_x : dp_b.dp_x + 32'h0001_0000;
  assign dp_b.dp_y_res = dp_copy ? dp_b.dp_up_y : dp_b.dp_y - 32'h0001_0000;

  constraint_sweep_ctrl #(.N_POINTS(4), .ITERS(1), .DP_LATENCY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .load_we(load_we_a), .load_addr(load_addr_a), .load_x(load_x_a), .load_y(load_y_a),
    .rd_addr(rd_addr_a), .rd_x(rd_x_a), .rd_y(rd_y_a), .dp(dp_a), .dbg_state(dbg_a)
  );

  constraint_sweep_ctrl #(.N_POINTS(4), .ITERS(3), .DP_LATENCY(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .load_we(load_we_b), .load_addr(load_addr_b), .load_x(load_x_b), .load_y(load_y_b),
    .rd_addr(rd_addr_b), .rd_x(rd_x_b), .rd_y(rd_y_b), .dp(dp_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic rd_req = 1'b0, rd_sel = 1'b0, rd_vld = 1'b0, rd_sel_q = 1'b0;
  always @(posedge clk) begin
    rd_vld   <= rd_req;
    rd_sel_q <= rd_sel;
  end

  int busy_cnt_a = 0, done_cnt_a = 0, busy_cnt_b = 0, done_cnt_b = 0, last_cnt_b = 0;
  int done_clean_a = 0;
  logic busy_prev_a = 1'b0;

  // Monitor: event counters plus readout comparison against the expected queue.
  always @(negedge clk) begin
    if (busy_a) busy_cnt_a++;
    if (done_a) begin
      done_cnt_a++;
      if (busy_prev_a && !busy_a) done_clean_a++;
    end
    busy_prev_a = busy_a;
    if (busy_b) busy_cnt_b++;
    if (done_b) done_cnt_b++;
    if (busy_b && dp_b.dp_is_last) begin
      last_cnt_b++;
      check("is_last_down_eq_cur", {dp_b.dp_down_x, dp_b.dp_down_y}, {dp_b.dp_x, dp_b.dp_y});
    end
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %h expected none", {rd_x_a, rd_y_a});
      end else begin
        check(name_q.pop_front(), rd_sel_q ? {rd_x_b, rd_y_b} : {rd_x_a, rd_y_a},
              exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pt(input bit b, input logic [1:0] a, input logic [31:0] x, input logic [31:0] y);
    if (b) begin load_we_b = 1; load_addr_b = a; load_x_b = x; load_y_b = y; end
    else   begin load_we_a = 1; load_addr_a = a; load_x_a = x; load_y_a = y; end
    tick();
    load_we_a = 0;
    load_we_b = 0;
  endtask

  task automatic do_start(input bit b);
    if (b) start_b = 1; else start_a = 1;
    tick();
    start_a = 0;
    start_b = 0;
  endtask

  task automatic rd_pt(input bit b, input logic [1:0] a, input logic [63:0] e, input string nm);
    rd_sel = b;
    if (b) rd_addr_b = a; else rd_addr_a = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    rd_req = 1;
    tick();
    rd_req = 0;
  endtask

  task automatic read_all(input bit b, input logic [63:0] e0, input logic [63:0] e1,
                          input logic [63:0] e2, input logic [63:0] e3, input string tag);
    rd_pt(b, 2'd0, e0, {tag, "_p0"});
    rd_pt(b, 2'd1, e1, {tag, "_p1"});
    rd_pt(b, 2'd2, e2, {tag, "_p2"});
    rd_pt(b, 2'd3, e3, {tag, "_p3"});
    tick();
    tick();
  endtask

  task automatic wait_done(input bit b, input int d0, input int budget, input string nm);
    int c = 0;
    while (((b ? done_cnt_b : done_cnt_a) == d0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(nm, 64'((b ? done_cnt_b : done_cnt_a) > d0), 64'd1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  int b0, d0, l0, c0;

  initial begin
    rst_n = 0; dp_copy = 0;
    start_a = 0; load_we_a = 0; load_addr_a = 0; load_x_a = 0; load_y_a = 0; rd_addr_a = 0;
    start_b = 0; load_we_b = 0; load_addr_b = 0; load_x_b = 0; load_y_b = 0; rd_addr_b = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Reset state.
    @(negedge clk);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_state", 64'(dbg_a), 64'(ST_IDLE));
    check("rst_dp_x", {dp_a.dp_x, dp_a.dp_y}, 64'd0);
    tick();
    rd_pt(0, 2'd3, 64'd0, "rst_rd_p3");

    // Timing: add datapath, all points zero.
    b0 = busy_cnt_a; d0 = done_cnt_a; c0 = done_clean_a;
    do_start(0);
    wait_done(0, d0, 100, "t_done_seen");
    repeat (3) tick();
    check("t_busy_cycles", 64'(busy_cnt_a - b0), 64'(BUSY_A));
    check("t_done_pulses", 64'(done_cnt_a - d0), 64'd1);
    check("t_done_after_busy", 64'(done_clean_a - c0), 64'd1);
    read_all(0, 64'd0, STEP1, STEP1, DUAL ? 64'd0 : STEP1, "t");

    // Gauss-Seidel ordering: copy-up datapath propagates the anchor down the chain.
    load_pt(0, 2'd0, 32'h0005_0000, 32'h0003_0000);
    for (int k = 1; k < 4; k++) load_pt(0, 2'(k), 32'd0, 32'd0);
    dp_copy = 1;
    d0 = done_cnt_a;
    do_start(0);
    wait_done(0, d0, 100, "gs_done_seen");
    read_all(0, ANCH, ANCH, ANCH, DUAL ? 64'd0 : ANCH, "gs");
    dp_copy = 0;

    // Ignored start/load mid-sweep.
    for (int k = 0; k < 4; k++) load_pt(0, 2'(k), 32'd0, 32'd0);
    b0 = busy_cnt_a; d0 = done_cnt_a;
    do_start(0);
    tick();
    tick();
    start_a = 1; load_we_a = 1; load_addr_a = 2'd2; load_x_a = 32'h7FFF_0000; load_y_a = 32'h7FFF_0000;
    tick();
    start_a = 0; load_we_a = 0;
    wait_done(0, d0, 100, "ign_done_seen");
    repeat (40) tick();
    check("ign_done_pulses", 64'(done_cnt_a - d0), 64'd1);
    check("ign_busy_cycles", 64'(busy_cnt_a - b0), 64'(BUSY_A));
    read_all(0, 64'd0, STEP1, STEP1, DUAL ? 64'd0 : STEP1, "ign");

    // Multi-pass and is_last on the ITERS=3 instance.
    b0 = busy_cnt_b; d0 = done_cnt_b; l0 = last_cnt_b;
    do_start(1);
    wait_done(1, d0, 200, "mp_done_seen");
    repeat (2) tick();
    check("mp_busy_cycles", 64'(busy_cnt_b - b0), 64'(BUSY_B));
    check("mp_is_last_cycles", 64'(last_cnt_b - l0), 64'(LAST_B));
    read_all(1, 64'd0, STEP3, STEP3, DUAL ? 64'd0 : STEP3, "mp");

    // Reset abort in the middle of the second point.
    for (int k = 0; k < 4; k++) load_pt(0, 2'(k), 32'h1111_0000, 32'h2222_0000);
    d0 = done_cnt_a;
    do_start(0);
    repeat (4) tick();
    rst_n = 0;
    @(negedge clk);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_state", 64'(dbg_a), 64'(ST_IDLE));
    check("abort_dp_up", {dp_a.dp_up_x, dp_a.dp_up_y}, 64'd0);
    check("abort_dp_cur", {dp_a.dp_x, dp_a.dp_y}, 64'd0);
    check("abort_dp_down", {dp_a.dp_down_x, dp_a.dp_down_y}, 64'd0);
    check("abort_is_last", 64'(dp_a.dp_is_last), 64'd0);
    tick();
    tick();
    rst_n = 1;
    repeat (20) tick();
    check("abort_no_done", 64'(done_cnt_a - d0), 64'd0);
    read_all(0, 64'd0, 64'd0, 64'd0, 64'd0, "abort");

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
